mario_poll_sequencer: RTL and testbench

Produces Mario's four collision poll codes (up/down/left/right) once per frame by reading the shared single-port level tile map. It also owns the horizontal scroll column that advances on Mario's Shift pulse. Map reads go through an external req/gnt arbiter, because the background renderer shares the map port and has priority. Sits between the tile-map RAM arbiter and the Mario movement block; scroll_col also feeds the renderer.

---
 rtl/mario_pkg.sv | 35 +++
 rtl/mario_probe_addr.sv | 31 +++
 rtl/mario_poll_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mario_poll_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// Shared playfield/tile constants plus the tile-code, probe and FSM types
// used by Mario's poll sequencer and the background renderer.
package mario_pkg;

  localparam logic [9:0] PF_X_MIN   = 10'd120;
  localparam logic [9:0] PF_Y_MIN   = 10'd40;
  localparam logic [9:0] PF_X_MAX   = 10'd519;
  localparam logic [9:0] PF_Y_MAX   = 10'd439;
  localparam logic [9:0] TILE_PX    = 10'd40;
  localparam logic [9:0] MARIO_HALF = 10'd20;

  localparam int MAP_COLS = 64;
  localparam int ADDR_W   = 10;
  localparam int COL_W    = $clog2(MAP_COLS);

  typedef logic [2:0] tile_t;
  localparam tile_t TILE_EMPTY = 3'b000;
  localparam tile_t TILE_SOLID = 3'b111;

  typedef enum logic [1:0] {
    PROBE_UP,
    PROBE_DOWN,
    PROBE_LEFT,
    PROBE_RIGHT
  } probe_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_REQ,
    ST_WAIT,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/mario_probe_addr.sv
// Combinational conversion of one probe pixel into an out-of-playfield flag
// and a scrolled tile-map address.
module mario_probe_addr
  import mario_pkg::*;
(
  input  logic [9:0]        i_px,
  input  logic [9:0]        i_py,
  input  logic [COL_W-1:0]  i_scroll,
  output logic              o_oob,
  output logic [ADDR_W-1:0] o_addr
);

  logic [9:0]       w_dx;
  logic [9:0]       w_dy;
  logic [9:0]       w_col;
  logic [9:0]       w_row;
  logic [COL_W-1:0] w_col_wrap;

  // Underflowed probes wrap far above the MAX bounds, so they land in o_oob.
  assign w_dx = i_px - PF_X_MIN;
  assign w_dy = i_py - PF_Y_MIN;

  assign w_col      = w_dx / TILE_PX;
  assign w_row      = w_dy / TILE_PX;
  assign w_col_wrap = COL_W'(w_col + 10'(i_scroll));

  assign o_oob  = (i_px < PF_X_MIN) || (i_px > PF_X_MAX) ||
                  (i_py < PF_Y_MIN) || (i_py > PF_Y_MAX);
  assign o_addr = ADDR_W'(32'(w_row) * MAP_COLS + 32'(w_col_wrap));

endmodule

// File: rtl/mario_poll_sequencer.sv
// Once per frame, reads the four tiles around Mario through the shared map
// arbiter and commits them together; also owns the scroll column.
module mario_poll_sequencer
  import mario_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        Mario_X_Pos,
  input  logic [9:0]        Mario_Y_Pos,
  input  logic              Shift,
  output logic              map_req,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_gnt,
  input  logic [2:0]        map_data,
  output logic [2:0]        mario_poll_up,
  output logic [2:0]        mario_poll_down,
  output logic [2:0]        mario_poll_left,
  output logic [2:0]        mario_poll_right,
  output logic              poll_valid,
  output logic              busy,
  output logic              overrun,
  output logic [COL_W-1:0]  scroll_col
);

  state_e            r_state;
  state_e            w_state_nxt;
  probe_e            r_p;
  logic              r_fc_q1;
  logic              r_fc_q2;
  logic              r_edge;
  logic [9:0]        r_snap_x;
  logic [9:0]        r_snap_y;
  logic [COL_W-1:0]  r_snap_scroll;
  logic [COL_W-1:0]  r_scroll;
  logic [ADDR_W-1:0] r_addr [4];
  logic [3:0]        r_oob;
  tile_t             r_slot [4];
  tile_t             r_up;
  tile_t             r_down;
  tile_t             r_left;
  tile_t             r_right;
  logic              r_poll_valid;
  logic              r_overrun;
  logic              w_map_req;

  logic [9:0]        w_px   [4];
  logic [9:0]        w_py   [4];
  logic [ADDR_W-1:0] w_addr [4];
  logic [3:0]        w_oob;

  assign w_px[PROBE_UP]    = r_snap_x;
  assign w_py[PROBE_UP]    = r_snap_y - MARIO_HALF - 10'd1;
  assign w_px[PROBE_DOWN]  = r_snap_x;
  assign w_py[PROBE_DOWN]  = r_snap_y + MARIO_HALF;
  assign w_px[PROBE_LEFT]  = r_snap_x - MARIO_HALF - 10'd1;
  assign w_py[PROBE_LEFT]  = r_snap_y;
  assign w_px[PROBE_RIGHT] = r_snap_x + MARIO_HALF;
  assign w_py[PROBE_RIGHT] = r_snap_y;

  for (genvar g = 0; g < 4; g++) begin : g_probe
    mario_probe_addr u_probe (
      .i_px     (w_px[g]),
      .i_py     (w_py[g]),
      .i_scroll (r_snap_scroll),
      .o_oob    (w_oob[g]),
      .o_addr   (w_addr[g])
    );
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_map_req   = 1'b0;
    case (r_state)
      ST_IDLE:   if (r_edge) w_state_nxt = ST_CALC;
      ST_CALC:   w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (r_oob[r_p]) begin
          if (r_p == PROBE_RIGHT) w_state_nxt = ST_COMMIT;
        end else begin
          w_map_req = 1'b1;
          if (map_gnt) w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT:   w_state_nxt = (r_p == PROBE_RIGHT) ? ST_COMMIT : ST_REQ;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fc_q1       <= 1'b0;
      r_fc_q2       <= 1'b0;
      r_edge        <= 1'b0;
      r_p           <= PROBE_UP;
      r_snap_x      <= '0;
      r_snap_y      <= '0;
      r_snap_scroll <= '0;
      r_scroll      <= '0;
      r_oob         <= '0;
      r_up          <= TILE_EMPTY;
      r_down        <= TILE_EMPTY;
      r_left        <= TILE_EMPTY;
      r_right       <= TILE_EMPTY;
      r_poll_valid  <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < 4; i++) r_addr[i] <= '0;
    end else begin
      r_fc_q1      <= frame_clk;
      r_fc_q2      <= r_fc_q1;
      r_edge       <= r_fc_q1 & ~r_fc_q2;
      r_poll_valid <= (r_state == ST_COMMIT);
      if (Shift) r_scroll <= r_scroll + 1'b1;
      // Edges during a running sequence are dropped, only flagged.
      if (r_edge && (r_state != ST_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (r_edge) begin
            r_snap_x      <= Mario_X_Pos;
            r_snap_y      <= Mario_Y_Pos;
            r_snap_scroll <= r_scroll;
          end
        end
        ST_CALC: begin
          for (int i = 0; i < 4; i++) r_addr[i] <= w_addr[i];
          r_oob <= w_oob;
          r_p   <= PROBE_UP;
        end
        ST_REQ: begin
          if (r_oob[r_p]) begin
            r_slot[r_p] <= TILE_SOLID;
            r_p         <= probe_e'(r_p + 2'd1);
          end
        end
        ST_WAIT: begin
          r_slot[r_p] <= map_data;
          r_p         <= probe_e'(r_p + 2'd1);
        end
        ST_COMMIT: begin
          r_up    <= r_slot[PROBE_UP];
          r_down  <= r_slot[PROBE_DOWN];
          r_left  <= r_slot[PROBE_LEFT];
          r_right <= r_slot[PROBE_RIGHT];
        end
        default: ;
      endcase
    end
  end

  assign map_req          = w_map_req;
  assign map_addr         = w_map_req ? r_addr[r_p] : '0;
  assign mario_poll_up    = r_up;
  assign mario_poll_down  = r_down;
  assign mario_poll_left  = r_left;
  assign mario_poll_right = r_right;
  assign poll_valid       = r_poll_valid;
  assign busy             = (r_state != ST_IDLE);
  assign overrun          = r_overrun;
  assign scroll_col       = r_scroll;

endmodule

// File: tb/tb_mario_poll_sequencer.sv
// Scoreboard bench for the poll sequencer: stimulus queues expected map
// addresses and commits; negedge monitors pop and compare them.
module tb_mario_poll_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] Mario_X_Pos = '0;
  logic [9:0] Mario_Y_Pos = '0;
  logic       Shift = 1'b0;
  logic       map_gnt = 1'b1;
  logic [2:0] map_data = '0;
  logic       map_req;
  logic [9:0] map_addr;
  logic [2:0] mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right;
  logic       poll_valid, busy, overrun;
  logic [5:0] scroll_col;

  mario_poll_sequencer dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_clk        (frame_clk),
    .Mario_X_Pos      (Mario_X_Pos),
    .Mario_Y_Pos      (Mario_Y_Pos),
    .Shift            (Shift),
    .map_req          (map_req),
    .map_addr         (map_addr),
    .map_gnt          (map_gnt),
    .map_data         (map_data),
    .mario_poll_up    (mario_poll_up),
    .mario_poll_down  (mario_poll_down),
    .mario_poll_left  (mario_poll_left),
    .mario_poll_right (mario_poll_right),
    .poll_valid       (poll_valid),
    .busy             (busy),
    .overrun          (overrun),
    .scroll_col       (scroll_col)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [11:0] polls;
    int          cyc;
  } poll_exp_t;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          stall_left = 0;
  logic        rd_pend = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [2:0]  mem [1024];
  logic [9:0]  q_addr [$];
  poll_exp_t   q_poll [$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [11:0] pk(input logic [2:0] u, d, l, r);
    return {u, d, l, r};
  endfunction

  // Arbiter model plus request/commit monitor.
  always @(negedge Clk) begin
    if (map_req === 1'b1) begin
      if (q_addr.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL addr_unexpected: request to %0d, required no request", map_addr);
        map_gnt = 1'b1;
      end else begin
        chk("map_addr", int'(map_addr), int'(q_addr[0]));
        if (stall_left > 0) begin
          map_gnt = 1'b0;
          stall_left--;
        end else begin
          map_gnt = 1'b1;
          void'(q_addr.pop_front());
          rd_addr = map_addr;
          rd_pend = 1'b1;
        end
      end
    end else begin
      map_gnt = 1'b1;
    end

    if (poll_valid === 1'b1) begin
      if (q_poll.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL poll_unexpected: poll_valid high, required low (cycle %0d)", cyc);
      end else begin
        poll_exp_t e;
        e = q_poll.pop_front();
        chk("poll_codes", int'({mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right}),
            int'(e.polls));
        chk("poll_cycle", cyc, e.cyc);
      end
    end
  end

  // Map RAM: data valid the cycle after grant, junk otherwise.
  initial forever begin
    @(posedge Clk);
    #1;
    if (rd_pend) begin
      map_data = mem[rd_addr];
      rd_pend  = 1'b0;
    end else begin
      map_data = 3'b111;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // E is two edges after frame_clk is first sampled high; lat counts from E.
  task automatic run_frame(input logic [9:0] x, input logic [9:0] y, input logic exp_commit,
                           input logic [11:0] polls, input int lat);
    poll_exp_t e;
    Mario_X_Pos = x;
    Mario_Y_Pos = y;
    @(posedge Clk);
    #1 frame_clk = 1'b1;
    if (exp_commit) begin
      e.polls = polls;
      e.cyc   = cyc + 2 + lat;
      q_poll.push_back(e);
    end
    repeat (2) @(posedge Clk);
    #1 frame_clk = 1'b0;
  endtask

  task automatic push3(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
    q_addr.push_back(a0);
    q_addr.push_back(a1);
    q_addr.push_back(a2);
  endtask

  task automatic shift_n(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1 Shift = 1'b1;
      @(posedge Clk);
      #1 Shift = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((q_poll.size() != 0 || q_addr.size() != 0) && k < budget) begin
      @(posedge Clk);
      k++;
    end
    chk("drain_pending", q_poll.size() + q_addr.size(), 0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("busy_after", int'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 3'b000;
    mem[576] = 3'd1;
    mem[198] = 3'd2; mem[262] = 3'd3; mem[261] = 3'd4; mem[263] = 3'd5;
    mem[75]  = 3'd6; mem[10]  = 3'd1;
    mem[71]  = 3'd3; mem[6]   = 3'd2;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_polls", int'({mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right}), 0);
    chk("rst_poll_valid", int'(poll_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_scroll", int'(scroll_col), 0);
    chk("rst_map_req", int'(map_req), 0);
    chk("rst_map_addr", int'(map_addr), 0);
    Reset = 1'b0;
    repeat (2) @(posedge Clk);

    // Left probe off-playfield: three reads, commit at E+10.
    push3(10'd512, 10'd576, 10'd577);
    run_frame(10'd140, 10'd419, 1'b1, pk(3'd0, 3'd1, 3'd7, 3'd0), 10);
    wait_drain(60);
    chk("overrun_clear", int'(overrun), 0);

    // First request stalled three cycles: commit at E+13.
    stall_left = 3;
    push3(10'd512, 10'd576, 10'd577);
    run_frame(10'd140, 10'd419, 1'b1, pk(3'd0, 3'd1, 3'd7, 3'd0), 13);
    wait_drain(60);

    // Second edge at E+5 is dropped and flags overrun.
    push3(10'd512, 10'd576, 10'd577);
    run_frame(10'd140, 10'd419, 1'b1, pk(3'd0, 3'd1, 3'd7, 3'd0), 10);
    repeat (3) @(posedge Clk);
    #1 frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1 frame_clk = 1'b0;
    wait_drain(60);
    repeat (20) @(posedge Clk);
    @(negedge Clk);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_no_rerun", int'(busy), 0);

    // Reset asserted at E+4 aborts the sequence.
    q_addr.push_back(10'd512);
    q_addr.push_back(10'd576);
    run_frame(10'd140, 10'd419, 1'b0, 12'd0, 0);
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("abort_map_req", int'(map_req), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_polls", int'({mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right}), 0);
    chk("abort_overrun", int'(overrun), 0);
    Reset = 1'b0;
    repeat (20) @(posedge Clk);
    chk("abort_reqs_left", q_addr.size(), 0);

    // Scroll wrap, then a scrolled frame with all probes in bounds.
    shift_n(1);
    @(negedge Clk);
    chk("scroll_one", int'(scroll_col), 1);
    shift_n(63);
    @(negedge Clk);
    chk("scroll_wrap", int'(scroll_col), 0);
    shift_n(2);
    @(negedge Clk);
    chk("scroll_two", int'(scroll_col), 2);
    push3(10'd198, 10'd262, 10'd261);
    q_addr.push_back(10'd263);
    run_frame(10'd300, 10'd200, 1'b1, pk(3'd2, 3'd3, 3'd4, 3'd5), 11);
    wait_drain(60);

    // Up and right probes off-playfield: two reads, commit at E+9.
    q_addr.push_back(10'd75);
    q_addr.push_back(10'd10);
    run_frame(10'd500, 10'd60, 1'b1, pk(3'd7, 3'd6, 3'd1, 3'd7), 9);
    wait_drain(60);

    // Scrolled column sum wraps modulo the map width.
    shift_n(60);
    @(negedge Clk);
    chk("scroll_62", int'(scroll_col), 62);
    q_addr.push_back(10'd71);
    q_addr.push_back(10'd6);
    run_frame(10'd500, 10'd60, 1'b1, pk(3'd7, 3'd3, 3'd2, 3'd7), 9);
    wait_drain(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
